// File: rtl/pgm_pkg.sv
// Shared types and constants for the PGM raster timing and 68k interrupt block.
// Holds IRQ levels, register indices, default timing and the 9-bit counter type.
package pgm_pkg;

    typedef logic [8:0] cnt_t;

    typedef enum logic [1:0] {
        REG_STATUS   = 2'd0,
        REG_ENABLE   = 2'd1,
        REG_LINE_CMP = 2'd2,
        REG_VCOUNT   = 2'd3
    } reg_idx_t;

    localparam int IRQ_VBL  = 6;
    localparam int IRQ_LINE = 4;

    localparam int DEF_H_TOTAL  = 512;
    localparam int DEF_H_ACTIVE = 448;
    localparam int DEF_HS_START = 464;
    localparam int DEF_HS_LEN   = 32;
    localparam int DEF_V_TOTAL  = 264;
    localparam int DEF_V_ACTIVE = 224;
    localparam int DEF_VS_START = 232;
    localparam int DEF_VS_LEN   = 3;

    // Priority encode the pending levels into the active-low fx68k IPL bus.
    function automatic logic [2:0] ipl_encode(input logic vbl, input logic line);
        logic [2:0] ipl;
        ipl = 3'b111;
        if (vbl) begin
            ipl = ~3'(IRQ_VBL);
        end else if (line) begin
            ipl = ~3'(IRQ_LINE);
        end
        return ipl;
    endfunction

endpackage

// File: rtl/pgm_video_counter.sv
// Raster counters with registered sync/blank and one-cycle VBL/scanline pulses.
// Ports: clk, reset, pix_ce, line_cmp in; hcount, vcount, syncs, blanks, evts out.
module pgm_video_counter
    import pgm_pkg::*;
#(
    parameter int H_TOTAL  = DEF_H_TOTAL,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int HS_START = DEF_HS_START,
    parameter int HS_LEN   = DEF_HS_LEN,
    parameter int V_TOTAL  = DEF_V_TOTAL,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int VS_START = DEF_VS_START,
    parameter int VS_LEN   = DEF_VS_LEN
) (
    input  logic clk,
    input  logic reset,
    input  logic pix_ce,
    input  cnt_t line_cmp,
    output cnt_t hcount,
    output cnt_t vcount,
    output logic hsync_n,
    output logic vsync_n,
    output logic hblank,
    output logic vblank,
    output logic vbl_evt,
    output logic line_evt
);

    localparam cnt_t H_LAST = cnt_t'(H_TOTAL - 1);
    localparam cnt_t V_LAST = cnt_t'(V_TOTAL - 1);
    localparam cnt_t V_TOT  = cnt_t'(V_TOTAL);
    localparam cnt_t H_ACT  = cnt_t'(H_ACTIVE);
    localparam cnt_t V_ACT  = cnt_t'(V_ACTIVE);
    localparam cnt_t HS_B   = cnt_t'(HS_START);
    localparam cnt_t HS_E   = cnt_t'(HS_START + HS_LEN);
    localparam cnt_t VS_B   = cnt_t'(VS_START);
    localparam cnt_t VS_E   = cnt_t'(VS_START + VS_LEN);

    logic h_wrap;
    cnt_t h_next;
    cnt_t v_next;

    always_comb begin
        h_wrap = (hcount == H_LAST);
        h_next = h_wrap ? '0 : hcount + cnt_t'(1);
        v_next = vcount;
        if (h_wrap) begin
            v_next = (vcount == V_LAST) ? '0 : vcount + cnt_t'(1);
        end
    end

    // Events flag the pix_ce edge on which the counters land on column 0 of the line.
    assign vbl_evt  = pix_ce && h_wrap && (v_next == V_ACT);
    assign line_evt = pix_ce && h_wrap && (v_next == line_cmp)
                      && (line_cmp < V_TOT);

    always_ff @(posedge clk) begin
        if (reset) begin
            hcount  <= '0;
            vcount  <= '0;
            hsync_n <= 1'b1;
            vsync_n <= 1'b1;
            hblank  <= 1'b0;
            vblank  <= 1'b0;
        end else if (pix_ce) begin
            hcount  <= h_next;
            vcount  <= v_next;
            hblank  <= (h_next >= H_ACT);
            vblank  <= (v_next >= V_ACT);
            hsync_n <= !((h_next >= HS_B) && (h_next < HS_E));
            vsync_n <= !((v_next >= VS_B) && (v_next < VS_E));
        end
    end

endmodule

// File: rtl/pgm_irq_timing.sv
// PGM raster timing, 68k IRQ pending/enable logic and B00000-B00007 register window.
// Ports: 68k bus (reg_*, as_n, rw_n, uds_n, lds_n), IACK, ipl_n, raster outputs.
// Optional scanline IRQ on level 4 is built when PGM_IRQ_LINE_EN is defined.
module pgm_irq_timing
    import pgm_pkg::*;
#(
    parameter int H_TOTAL  = DEF_H_TOTAL,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int HS_START = DEF_HS_START,
    parameter int HS_LEN   = DEF_HS_LEN,
    parameter int V_TOTAL  = DEF_V_TOTAL,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int VS_START = DEF_VS_START,
    parameter int VS_LEN   = DEF_VS_LEN
) (
    input  logic        fixed_20m_clk,
    input  logic        reset,
    input  logic        pix_ce,
    input  logic        reg_cs,
    input  logic        as_n,
    input  logic        rw_n,
    input  logic        uds_n,
    input  logic        lds_n,
    input  logic [1:0]  reg_addr,
    input  logic [15:0] reg_din,
    output logic [15:0] reg_dout,
    output logic        reg_dtack_n,
    input  logic        iack,
    input  logic [2:0]  iack_level,
    output logic [2:0]  ipl_n,
    output cnt_t        hcount,
    output cnt_t        vcount,
    output logic        hsync_n,
    output logic        vsync_n,
    output logic        hblank,
    output logic        vblank
);

    logic     vbl_evt;
    logic     line_evt;
    cnt_t     line_cmp;
    logic     pend6, en6;
    logic     pend4, en4;
    logic     strobe, strobe_q, acc, wr, lo_we;
    logic     iack_act, iack_q, iack_rise;
    logic     st_lo, en_lo;
    logic     clr6, set6;
    logic     unused_ok;
    logic [15:0] rdata;
    reg_idx_t idx;

    pgm_video_counter #(
        .H_TOTAL  (H_TOTAL),
        .H_ACTIVE (H_ACTIVE),
        .HS_START (HS_START),
        .HS_LEN   (HS_LEN),
        .V_TOTAL  (V_TOTAL),
        .V_ACTIVE (V_ACTIVE),
        .VS_START (VS_START),
        .VS_LEN   (VS_LEN)
    ) u_cnt (
        .clk      (fixed_20m_clk),
        .reset    (reset),
        .pix_ce   (pix_ce),
        .line_cmp (line_cmp),
        .hcount   (hcount),
        .vcount   (vcount),
        .hsync_n  (hsync_n),
        .vsync_n  (vsync_n),
        .hblank   (hblank),
        .vblank   (vblank),
        .vbl_evt  (vbl_evt),
        .line_evt (line_evt)
    );

    assign idx       = reg_idx_t'(reg_addr);
    assign strobe    = reg_cs && !as_n;
    assign acc       = strobe && !strobe_q;
    assign wr        = acc && !rw_n;
    assign lo_we     = wr && !lds_n;
    assign st_lo     = lo_we && (idx == REG_STATUS);
    assign en_lo     = lo_we && (idx == REG_ENABLE);
    assign iack_act  = iack && !as_n;
    assign iack_rise = iack_act && !iack_q;

    // Edge detectors keep sampling through reset, so a strobe held across
    // reset is not mistaken for a fresh access once reset releases.
    always_ff @(posedge fixed_20m_clk) begin
        strobe_q <= strobe;
        iack_q   <= iack_act;
    end

    always_ff @(posedge fixed_20m_clk) begin
        if (reset) begin
            reg_dtack_n <= 1'b1;
        end else begin
            reg_dtack_n <= !(strobe && (acc || !reg_dtack_n));
        end
    end

    assign clr6 = (st_lo && reg_din[IRQ_VBL])
               || (en_lo && !reg_din[IRQ_VBL])
               || (iack_rise && (iack_level == 3'(IRQ_VBL)));
    assign set6 = vbl_evt && en6;

    // Set is ORed after the clear so a coincident event is never lost.
    always_ff @(posedge fixed_20m_clk) begin
        if (reset) begin
            pend6 <= 1'b0;
            en6   <= 1'b0;
        end else begin
            pend6 <= set6 || (pend6 && !clr6);
            if (en_lo) begin
                en6 <= reg_din[IRQ_VBL];
            end
        end
    end

`ifdef PGM_IRQ_LINE_EN
    logic hi_we, clr4, set4, lc_sel;

    assign hi_we  = wr && !uds_n;
    assign lc_sel = (idx == REG_LINE_CMP);
    assign clr4   = (st_lo && reg_din[IRQ_LINE])
                 || (en_lo && !reg_din[IRQ_LINE])
                 || (iack_rise && (iack_level == 3'(IRQ_LINE)));
    assign set4   = line_evt && en4;

    always_ff @(posedge fixed_20m_clk) begin
        if (reset) begin
            pend4    <= 1'b0;
            en4      <= 1'b0;
            line_cmp <= '0;
        end else begin
            pend4 <= set4 || (pend4 && !clr4);
            if (en_lo) begin
                en4 <= reg_din[IRQ_LINE];
            end
            if (lo_we && lc_sel) begin
                line_cmp[7:0] <= reg_din[7:0];
            end
            if (hi_we && lc_sel) begin
                line_cmp[8] <= reg_din[8];
            end
        end
    end

    assign unused_ok = ^reg_din[15:9];
`else
    assign pend4     = 1'b0;
    assign en4       = 1'b0;
    assign line_cmp  = '0;
    assign unused_ok = ^{reg_din, uds_n, line_evt};
`endif

    always_comb begin
        rdata = '0;
        unique case (idx)
            REG_STATUS: begin
                rdata[IRQ_VBL]  = pend6;
                rdata[IRQ_LINE] = pend4;
            end
            REG_ENABLE: begin
                rdata[IRQ_VBL]  = en6;
                rdata[IRQ_LINE] = en4;
            end
            REG_LINE_CMP: rdata[8:0] = line_cmp;
            REG_VCOUNT:   rdata[8:0] = vcount;
        endcase
    end

    always_ff @(posedge fixed_20m_clk) begin
        if (reset) begin
            ipl_n    <= 3'b111;
            reg_dout <= '0;
        end else begin
            ipl_n <= ipl_encode(pend6, pend4);
            if (acc && rw_n) begin
                reg_dout <= rdata;
            end
        end
    end

endmodule

// File: tb/tb_pgm_irq_timing.sv
// Self-checking bench for pgm_irq_timing using a shrunken raster.
// Counter model is derived from a running count of pix_ce ticks since reset.
module tb_pgm_irq_timing;

    localparam int TH  = 32;
    localparam int TA  = 24;
    localparam int HSS = 26;
    localparam int HSL = 3;
    localparam int TV  = 20;
    localparam int VA  = 14;
    localparam int VSS = 16;
    localparam int VSL = 2;
    localparam int F   = TH * TV;

    localparam logic [1:0] A_STATUS = 2'd0;
    localparam logic [1:0] A_ENABLE = 2'd1;
    localparam logic [1:0] A_LCMP   = 2'd2;
    localparam logic [1:0] A_VCNT   = 2'd3;

    logic        fixed_20m_clk = 1'b0;
    logic        reset = 1'b1;
    logic        pix_ce = 1'b0;
    logic        reg_cs = 1'b0;
    logic        as_n = 1'b1;
    logic        rw_n = 1'b1;
    logic        uds_n = 1'b1;
    logic        lds_n = 1'b1;
    logic [1:0]  reg_addr = '0;
    logic [15:0] reg_din = '0;
    logic [15:0] reg_dout;
    logic        reg_dtack_n;
    logic        iack = 1'b0;
    logic [2:0]  iack_level = '0;
    logic [2:0]  ipl_n;
    logic [8:0]  hcount, vcount;
    logic        hsync_n, vsync_n, hblank, vblank;

    int n_cmp = 0;
    int n_bad = 0;
    int ticks = 0;

    pgm_irq_timing #(
        .H_TOTAL (TH), .H_ACTIVE (TA), .HS_START (HSS), .HS_LEN (HSL),
        .V_TOTAL (TV), .V_ACTIVE (VA), .VS_START (VSS), .VS_LEN (VSL)
    ) dut (
        .fixed_20m_clk (fixed_20m_clk),
        .reset         (reset),
        .pix_ce        (pix_ce),
        .reg_cs        (reg_cs),
        .as_n          (as_n),
        .rw_n          (rw_n),
        .uds_n         (uds_n),
        .lds_n         (lds_n),
        .reg_addr      (reg_addr),
        .reg_din       (reg_din),
        .reg_dout      (reg_dout),
        .reg_dtack_n   (reg_dtack_n),
        .iack          (iack),
        .iack_level    (iack_level),
        .ipl_n         (ipl_n),
        .hcount        (hcount),
        .vcount        (vcount),
        .hsync_n       (hsync_n),
        .vsync_n       (vsync_n),
        .hblank        (hblank),
        .vblank        (vblank)
    );

    always #5 fixed_20m_clk = ~fixed_20m_clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: sim time expired");
        $fatal(1, "watchdog");
    end

    task automatic tick(input logic ce);
        logic r;
        pix_ce = ce;
        r = reset;
        @(posedge fixed_20m_clk);
        #1;
        if (r) ticks = 0;
        else if (ce) ticks++;
    endtask

    task automatic run_to(input int target);
        for (int i = 0; i < 5000 && ticks < target; i++) tick(1'b1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(1'b1);
        tick(1'b0);
        reset = 1'b0;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [15:0] d,
                             input logic u, input logic l, input logic ce0);
        int n;
        reg_cs = 1'b1; as_n = 1'b0; rw_n = 1'b0;
        reg_addr = a; reg_din = d; uds_n = u; lds_n = l;
        tick(ce0);
        n = 0;
        while (reg_dtack_n && n < 4) begin
            tick(1'b0);
            n++;
        end
        n_cmp++;
        if (reg_dtack_n !== 1'b0 || n != 0) begin
            n_bad++;
            $display("FAIL wr_dtack: got %b after %0d, want 0 after 0",
                     reg_dtack_n, n);
        end
        reg_cs = 1'b0; as_n = 1'b1; rw_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
        tick(1'b0);
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [15:0] d);
        int n;
        reg_cs = 1'b1; as_n = 1'b0; rw_n = 1'b1;
        reg_addr = a; uds_n = 1'b0; lds_n = 1'b0;
        tick(1'b0);
        n = 0;
        while (reg_dtack_n && n < 4) begin
            tick(1'b0);
            n++;
        end
        n_cmp++;
        if (reg_dtack_n !== 1'b0 || n != 0) begin
            n_bad++;
            $display("FAIL rd_dtack: got %b after %0d, want 0 after 0",
                     reg_dtack_n, n);
        end
        d = reg_dout;
        reg_cs = 1'b0; as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
        tick(1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(1'b1);
        n_cmp++;
        if ({hcount, vcount} !== 18'd0) begin
            n_bad++;
            $display("FAIL rst_cnt: got %0d/%0d want 0/0", hcount, vcount);
        end
        n_cmp++;
        if ({hsync_n, vsync_n, hblank, vblank} !== 4'b1100) begin
            n_bad++;
            $display("FAIL rst_sync: got %b want 1100",
                     {hsync_n, vsync_n, hblank, vblank});
        end
        n_cmp++;
        if (ipl_n !== 3'b111 || reg_dtack_n !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_ipl: got %b/%b want 111/1", ipl_n, reg_dtack_n);
        end
        n_cmp++;
        if (reg_dout !== 16'h0) begin
            n_bad++;
            $display("FAIL rst_dout: got %h want 0000", reg_dout);
        end
        reset = 1'b0;
    endtask

    task automatic test_free_run();
        int eh, ev, last_rise;
        logic pv, ce;
        do_reset();
        last_rise = -1;
        pv = 1'b0;
        for (int i = 0; i < 2500; i++) begin
            ce = ($urandom_range(0, 3) != 0);
            tick(ce);
            eh = ticks % TH;
            ev = (ticks / TH) % TV;
            n_cmp++;
            if (hcount !== 9'(eh)) begin
                n_bad++;
                $display("FAIL hcount: got %0d want %0d", hcount, eh);
            end
            n_cmp++;
            if (vcount !== 9'(ev)) begin
                n_bad++;
                $display("FAIL vcount: got %0d want %0d", vcount, ev);
            end
            n_cmp++;
            if (hblank !== (eh >= TA)) begin
                n_bad++;
                $display("FAIL hblank: got %b at h=%0d", hblank, eh);
            end
            n_cmp++;
            if (vblank !== (ev >= VA)) begin
                n_bad++;
                $display("FAIL vblank: got %b at v=%0d", vblank, ev);
            end
            n_cmp++;
            if (hsync_n !== !(eh >= HSS && eh < HSS + HSL)) begin
                n_bad++;
                $display("FAIL hsync_n: got %b at h=%0d", hsync_n, eh);
            end
            n_cmp++;
            if (vsync_n !== !(ev >= VSS && ev < VSS + VSL)) begin
                n_bad++;
                $display("FAIL vsync_n: got %b at v=%0d", vsync_n, ev);
            end
            if (vblank && !pv) begin
                if (last_rise >= 0) begin
                    n_cmp++;
                    if (ticks - last_rise != F) begin
                        n_bad++;
                        $display("FAIL frame_period: got %0d want %0d",
                                 ticks - last_rise, F);
                    end
                end
                last_rise = ticks;
            end
            pv = vblank;
        end
    endtask

    task automatic test_vbl_irq();
        logic [15:0] d;
        do_reset();
        bus_write(A_ENABLE, 16'h0040, 1'b0, 1'b0, 1'b0);
        bus_read(A_ENABLE, d);
        n_cmp++;
        if (d !== 16'h0040) begin
            n_bad++;
            $display("FAIL enable_rd: got %h want 0040", d);
        end
        bus_read(A_STATUS, d);
        n_cmp++;
        if (d !== 16'h0000) begin
            n_bad++;
            $display("FAIL status_idle: got %h want 0000", d);
        end
        run_to(VA * TH);
        n_cmp++;
        if (ipl_n !== 3'b111 || vcount !== 9'(VA) || hcount !== 9'd0) begin
            n_bad++;
            $display("FAIL vbl_edge: got ipl %b v%0d h%0d want 111 v%0d h0",
                     ipl_n, vcount, hcount, VA);
        end
        tick(1'b0);
        n_cmp++;
        if (ipl_n !== 3'b001) begin
            n_bad++;
            $display("FAIL vbl_ipl: got %b want 001", ipl_n);
        end
        bus_read(A_STATUS, d);
        n_cmp++;
        if (d !== 16'h0040) begin
            n_bad++;
            $display("FAIL vbl_status: got %h want 0040", d);
        end
    endtask

    task automatic test_iack();
        logic [15:0] d;
        iack = 1'b1; as_n = 1'b0; iack_level = 3'd4;
        tick(1'b0);
        tick(1'b0);
        n_cmp++;
        if (ipl_n !== 3'b001) begin
            n_bad++;
            $display("FAIL iack4_noop: got %b want 001", ipl_n);
        end
        iack = 1'b0; as_n = 1'b1;
        tick(1'b0);
        iack = 1'b1; as_n = 1'b0; iack_level = 3'd6;
        tick(1'b0);
        n_cmp++;
        if (ipl_n !== 3'b001) begin
            n_bad++;
            $display("FAIL iack6_lat: got %b want 001", ipl_n);
        end
        tick(1'b0);
        n_cmp++;
        if (ipl_n !== 3'b111) begin
            n_bad++;
            $display("FAIL iack6_clr: got %b want 111", ipl_n);
        end
        iack = 1'b0; as_n = 1'b1;
        tick(1'b0);
        iack = 1'b1; as_n = 1'b0; iack_level = 3'd4;
        tick(1'b0);
        iack = 1'b0; as_n = 1'b1;
        tick(1'b0);
        bus_read(A_STATUS, d);
        n_cmp++;
        if (d !== 16'h0000 || ipl_n !== 3'b111) begin
            n_bad++;
            $display("FAIL iack_after: got %h/%b want 0000/111", d, ipl_n);
        end
    endtask

    task automatic test_set_wins();
        logic [15:0] d;
        int t;
        t = (ticks / F) * F + VA * TH;
        while (t <= ticks + 1) t += F;
        run_to(t - 1);
        bus_write(A_STATUS, 16'h0040, 1'b0, 1'b0, 1'b1);
        bus_read(A_STATUS, d);
        n_cmp++;
        if (d !== 16'h0040 || ipl_n !== 3'b001) begin
            n_bad++;
            $display("FAIL set_wins: got %h/%b want 0040/001", d, ipl_n);
        end
        bus_write(A_STATUS, 16'h0040, 1'b0, 1'b0, 1'b0);
        bus_read(A_STATUS, d);
        n_cmp++;
        if (d !== 16'h0000 || ipl_n !== 3'b111) begin
            n_bad++;
            $display("FAIL w1c: got %h/%b want 0000/111", d, ipl_n);
        end
        run_to(t + F);
        tick(1'b0);
        bus_write(A_ENABLE, 16'h0000, 1'b0, 1'b0, 1'b0);
        bus_read(A_STATUS, d);
        n_cmp++;
        if (d !== 16'h0000 || ipl_n !== 3'b111) begin
            n_bad++;
            $display("FAIL en_clr: got %h/%b want 0000/111", d, ipl_n);
        end
    endtask

    task automatic test_regs();
        logic [15:0] d;
        do_reset();
        run_to($urandom_range(40, 500));
        bus_write(A_VCNT, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        bus_read(A_VCNT, d);
        n_cmp++;
        if (d !== 16'((ticks / TH) % TV)) begin
            n_bad++;
            $display("FAIL vcount_rd: got %h want %h", d,
                     16'((ticks / TH) % TV));
        end
        n_cmp++;
        if (reg_dtack_n !== 1'b1) begin
            n_bad++;
            $display("FAIL dtack_rel: got %b want 1", reg_dtack_n);
        end
        bus_write(A_ENABLE, 16'h0040, 1'b0, 1'b1, 1'b0);
        bus_read(A_ENABLE, d);
        n_cmp++;
        if (d !== 16'h0000) begin
            n_bad++;
            $display("FAIL byte_gate: got %h want 0000", d);
        end
    endtask

`ifdef PGM_IRQ_LINE_EN
    task automatic test_line_irq();
        logic [15:0] d;
        int l;
        do_reset();
        l = $urandom_range(1, VA - 1);
        bus_write(A_LCMP, 16'(l), 1'b0, 1'b0, 1'b0);
        bus_write(A_ENABLE, 16'h0050, 1'b0, 1'b0, 1'b0);
        bus_read(A_LCMP, d);
        n_cmp++;
        if (d !== 16'(l)) begin
            n_bad++;
            $display("FAIL lcmp_rd: got %h want %h", d, 16'(l));
        end
        run_to(l * TH);
        tick(1'b0);
        n_cmp++;
        if (ipl_n !== 3'b011) begin
            n_bad++;
            $display("FAIL line_ipl: got %b want 011", ipl_n);
        end
        bus_read(A_STATUS, d);
        n_cmp++;
        if (d !== 16'h0010) begin
            n_bad++;
            $display("FAIL line_status: got %h want 0010", d);
        end
        run_to(VA * TH);
        tick(1'b0);
        n_cmp++;
        if (ipl_n !== 3'b001) begin
            n_bad++;
            $display("FAIL line_vbl_ipl: got %b want 001", ipl_n);
        end
        bus_write(A_STATUS, 16'h0040, 1'b0, 1'b0, 1'b0);
        bus_read(A_STATUS, d);
        n_cmp++;
        if (d !== 16'h0010 || ipl_n !== 3'b011) begin
            n_bad++;
            $display("FAIL line_fallback: got %h/%b want 0010/011", d, ipl_n);
        end
        bus_write(A_STATUS, 16'h0010, 1'b0, 1'b0, 1'b0);
        bus_write(A_ENABLE, 16'h0010, 1'b0, 1'b0, 1'b0);
        bus_write(A_LCMP, 16'h01FF, 1'b1, 1'b0, 1'b0);
        bus_read(A_LCMP, d);
        n_cmp++;
        if (d !== 16'h00FF) begin
            n_bad++;
            $display("FAIL lcmp_lo: got %h want 00ff", d);
        end
        bus_write(A_LCMP, 16'h0100, 1'b0, 1'b1, 1'b0);
        bus_read(A_LCMP, d);
        n_cmp++;
        if (d !== 16'h01FF) begin
            n_bad++;
            $display("FAIL lcmp_hi: got %h want 01ff", d);
        end
        run_to(ticks + F + TH);
        bus_read(A_STATUS, d);
        n_cmp++;
        if (d !== 16'h0000 || ipl_n !== 3'b111) begin
            n_bad++;
            $display("FAIL lcmp_oob: got %h/%b want 0000/111", d, ipl_n);
        end
    endtask
`else
    task automatic test_line_off();
        logic [15:0] d;
        do_reset();
        bus_write(A_ENABLE, 16'h0050, 1'b0, 1'b0, 1'b0);
        bus_read(A_ENABLE, d);
        n_cmp++;
        if (d !== 16'h0040) begin
            n_bad++;
            $display("FAIL en4_off: got %h want 0040", d);
        end
        bus_write(A_LCMP, 16'h0005, 1'b0, 1'b0, 1'b0);
        bus_read(A_LCMP, d);
        n_cmp++;
        if (d !== 16'h0000) begin
            n_bad++;
            $display("FAIL lcmp_off: got %h want 0000", d);
        end
        run_to(ticks + F + TH);
        tick(1'b0);
        n_cmp++;
        if (ipl_n !== 3'b001) begin
            n_bad++;
            $display("FAIL off_vbl: got %b want 001", ipl_n);
        end
    endtask
`endif

    task automatic test_reset_mid_write();
        logic [15:0] d;
        do_reset();
        run_to($urandom_range(40, 300));
        reg_cs = 1'b1; as_n = 1'b0; rw_n = 1'b0;
        reg_addr = A_ENABLE; reg_din = 16'h0040; uds_n = 1'b0; lds_n = 1'b0;
        tick(1'b1);
        n_cmp++;
        if (reg_dtack_n !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_dtack: got %b want 0", reg_dtack_n);
        end
        reset = 1'b1;
        tick(1'b1);
        n_cmp++;
        if (reg_dtack_n !== 1'b1 || ipl_n !== 3'b111 || reg_dout !== 16'h0) begin
            n_bad++;
            $display("FAIL mid_rst: got %b/%b/%h want 1/111/0000",
                     reg_dtack_n, ipl_n, reg_dout);
        end
        n_cmp++;
        if ({hcount, vcount} !== 18'd0) begin
            n_bad++;
            $display("FAIL mid_rst_cnt: got %0d/%0d want 0/0", hcount, vcount);
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(1'b1);
            n_cmp++;
            if (reg_dtack_n !== 1'b1) begin
                n_bad++;
                $display("FAIL held_dtack: got %b want 1", reg_dtack_n);
            end
        end
        n_cmp++;
        if (hcount !== 9'(ticks % TH)) begin
            n_bad++;
            $display("FAIL post_rst_h: got %0d want %0d", hcount, ticks % TH);
        end
        reg_cs = 1'b0; as_n = 1'b1; rw_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
        tick(1'b0);
        bus_read(A_ENABLE, d);
        n_cmp++;
        if (d !== 16'h0000) begin
            n_bad++;
            $display("FAIL held_nowrite: got %h want 0000", d);
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_vbl_irq();
        test_iack();
        test_set_wins();
        test_regs();
`ifdef PGM_IRQ_LINE_EN
        test_line_irq();
`else
        test_line_off();
`endif
        test_reset_mid_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
